st_video_bbox_tracker: RTL

ST_VIDEO_BBOX_TRACKER -- requirements
Module: st_video_bbox_tracker

---
 rtl/st_video_bbox_tracker.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/st_video_bbox_tracker.sv
// Avalon-ST video pass-through stage that finds the bounding box of pixels
// matching an RGB threshold, latches it per frame, and can draw it back
// onto the following frames. Register file on a small Avalon-MM slave.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | between packets; beats pass through, no statistics
// ST_VIDEO | inside a video packet; non-SOP beats are pixels
// ST_OTHER | inside a control/ancillary packet; beats pass unchanged
module st_video_bbox_tracker #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] sink_data,
   input  logic        sink_valid,
   input  logic        sink_startofpacket,
   input  logic        sink_endofpacket,
   output logic        sink_ready,
   output logic [23:0] source_data,
   output logic        source_valid,
   output logic        source_startofpacket,
   output logic        source_endofpacket,
   input  logic        source_ready,
   input  logic [2:0]  s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_VIDEO, ST_OTHER} state_t;

   localparam logic [10:0] LP_XMAX = 11'(WIDTH - 1);
   localparam logic [10:0] LP_H    = 11'(HEIGHT);

   state_t      r_state, w_state_nxt;
   logic [23:0] r_src_data;
   logic        r_src_valid, r_src_sop, r_src_eop;
   logic [10:0] r_x, r_y;
   logic [10:0] r_min_x, r_max_x, r_min_y, r_max_y;
   logic [19:0] r_match_cnt;
   logic [10:0] r_res_min_x, r_res_max_x, r_res_min_y, r_res_max_y;
   logic [19:0] r_res_cnt;
   logic        r_result_valid, r_empty;
   logic [15:0] r_frame_cnt, r_err_cnt;
   logic [23:0] r_thr, r_colour;
   logic        r_draw;

   logic        w_sink_ready, w_xfer, w_pixel, w_sop_err, w_latch, w_match, w_first;
   logic [10:0] w_upd_min_x, w_upd_max_x, w_upd_min_y, w_upd_max_y;
   logic [19:0] w_upd_cnt, w_fin_cnt;
   logic        w_on_vert, w_on_horz, w_draw_hit;
   logic [23:0] w_out_data;
   logic [31:0] w_rd;
   logic        w_unused;

   assign w_sink_ready         = source_ready | ~r_src_valid;
   assign w_xfer               = sink_valid & w_sink_ready;
   assign sink_ready           = w_sink_ready;
   assign source_data          = r_src_data;
   assign source_valid         = r_src_valid;
   assign source_startofpacket = r_src_sop;
   assign source_endofpacket   = r_src_eop;
   assign w_unused             = ^s_writedata[31:24];

   // packet-type state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // packet decode: SOP selects type from data[3:0], EOP returns to idle
   always_comb begin
      w_state_nxt = r_state;
      w_pixel     = w_xfer & ~sink_startofpacket & (r_state == ST_VIDEO);
      w_sop_err   = w_xfer & sink_startofpacket & (r_state != ST_IDLE);
      w_latch     = w_pixel & sink_endofpacket;
      if (w_xfer) begin
         if (sink_startofpacket)
            w_state_nxt = (sink_data[3:0] == 4'h0) ? ST_VIDEO : ST_OTHER;
         if (sink_endofpacket)
            w_state_nxt = ST_IDLE;
      end
   end

   // match test and running bbox including the current pixel
   always_comb begin
      w_match     = w_pixel & (r_y < LP_H) & (sink_data[23:16] >= r_thr[7:0]) &
                    (sink_data[15:8] <= r_thr[15:8]) & (sink_data[7:0] <= r_thr[23:16]);
      w_first     = (r_match_cnt == 20'd0);
      w_upd_min_x = (w_first || r_x < r_min_x) ? r_x : r_min_x;
      w_upd_max_x = (w_first || r_x > r_max_x) ? r_x : r_max_x;
      w_upd_min_y = (w_first || r_y < r_min_y) ? r_y : r_min_y;
      w_upd_max_y = (w_first || r_y > r_max_y) ? r_y : r_max_y;
      w_upd_cnt   = (r_match_cnt == 20'hFFFFF) ? r_match_cnt : r_match_cnt + 20'd1;
      w_fin_cnt   = w_match ? w_upd_cnt : r_match_cnt;
   end

   // overlay uses the bbox latched from the previous video frame
   always_comb begin
      w_on_vert  = (r_x == r_res_min_x || r_x == r_res_max_x) &&
                   (r_y >= r_res_min_y) && (r_y <= r_res_max_y);
      w_on_horz  = (r_y == r_res_min_y || r_y == r_res_max_y) &&
                   (r_x >= r_res_min_x) && (r_x <= r_res_max_x);
      w_draw_hit = w_pixel & r_draw & ~r_empty & (w_on_vert | w_on_horz);
      w_out_data = w_draw_hit ? r_colour : sink_data;
   end

   // single output register stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src_valid <= 1'b0;
         r_src_data  <= '0;
         r_src_sop   <= 1'b0;
         r_src_eop   <= 1'b0;
      end else if (w_sink_ready) begin
         r_src_valid <= sink_valid;
         if (sink_valid) begin
            r_src_data <= w_out_data;
            r_src_sop  <= sink_startofpacket;
            r_src_eop  <= sink_endofpacket;
         end
      end
   end

   // pixel coordinates; y saturates so runaway packets cannot wrap into range
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_xfer && sink_startofpacket) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_pixel) begin
         if (r_x == LP_XMAX) begin
            r_x <= '0;
            if (r_y != 11'h7FF) r_y <= r_y + 11'd1;
         end else begin
            r_x <= r_x + 11'd1;
         end
      end
   end

   // per-frame statistics, restarted at every SOP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_min_x <= '0; r_max_x <= '0; r_min_y <= '0; r_max_y <= '0;
         r_match_cnt <= '0;
      end else if (w_xfer && sink_startofpacket) begin
         r_min_x <= '0; r_max_x <= '0; r_min_y <= '0; r_max_y <= '0;
         r_match_cnt <= '0;
      end else if (w_match) begin
         r_min_x <= w_upd_min_x; r_max_x <= w_upd_max_x;
         r_min_y <= w_upd_min_y; r_max_y <= w_upd_max_y;
         r_match_cnt <= w_upd_cnt;
      end
   end

   // frame results, status flags and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_res_min_x <= '0; r_res_max_x <= '0; r_res_min_y <= '0; r_res_max_y <= '0;
         r_res_cnt <= '0; r_result_valid <= 1'b0; r_empty <= 1'b0;
         r_frame_cnt <= '0; r_err_cnt <= '0;
      end else begin
         if (w_latch) begin
            r_res_cnt      <= w_fin_cnt;
            r_empty        <= (w_fin_cnt == 20'd0);
            r_result_valid <= 1'b1;
            r_frame_cnt    <= r_frame_cnt + 16'd1;
            if (w_fin_cnt == 20'd0) begin
               r_res_min_x <= '0; r_res_max_x <= '0; r_res_min_y <= '0; r_res_max_y <= '0;
            end else if (w_match) begin
               r_res_min_x <= w_upd_min_x; r_res_max_x <= w_upd_max_x;
               r_res_min_y <= w_upd_min_y; r_res_max_y <= w_upd_max_y;
            end else begin
               r_res_min_x <= r_min_x; r_res_max_x <= r_max_x;
               r_res_min_y <= r_min_y; r_res_max_y <= r_max_y;
            end
         end else if (s_read && s_address == 3'd0) begin
            r_result_valid <= 1'b0;
         end
         if (w_sop_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   // writable configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_thr    <= 24'h4040C0;
         r_draw   <= 1'b0;
         r_colour <= 24'h00FF00;
      end else if (s_write) begin
         case (s_address)
            3'd4:    r_thr    <= s_writedata[23:0];
            3'd5:    r_draw   <= s_writedata[0];
            3'd6:    r_colour <= s_writedata[23:0];
            default: ;
         endcase
      end
   end

   // zero-wait-state read mux
   always_comb begin
      w_rd = '0;
      case (s_address)
         3'd0: w_rd = {r_frame_cnt, 14'b0, r_empty, r_result_valid};
         3'd1: w_rd = {5'b0, r_res_max_x, 5'b0, r_res_min_x};
         3'd2: w_rd = {5'b0, r_res_max_y, 5'b0, r_res_min_y};
         3'd3: w_rd = {12'b0, r_res_cnt};
         3'd4: w_rd = {8'b0, r_thr};
         3'd5: w_rd = {31'b0, r_draw};
         3'd6: w_rd = {8'b0, r_colour};
         3'd7: w_rd = {16'b0, r_err_cnt};
         default: w_rd = '0;
      endcase
      s_readdata = s_read ? w_rd : 32'd0;
   end

endmodule
